// File: rtl/dual_port_ram_ctrl.sv
// Single-clock true dual-port RAM with a post-reset clear sequencer,
// selectable read-during-write behaviour and fixed write-collision priority.
module dual_port_ram_ctrl #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 15,
    parameter int unsigned       RD_MODE   = 0,
    parameter int unsigned       COLL_PRIO = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] write_addr_1,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic              re_1,
    input  logic [ADDR_W-1:0] read_addr_1,
    output logic [DATA_W-1:0] data_out_1,
    output logic              valid_1,
    input  logic              we_2,
    input  logic [ADDR_W-1:0] write_addr_2,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic              re_2,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] data_out_2,
    output logic              valid_2,
    output logic              busy,
    output logic              collision
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready_c;
    logic              coll_c;
    logic              wr_1_c;
    logic              wr_2_c;
    logic [DATA_W-1:0] rd_1_c;
    logic [DATA_W-1:0] rd_2_c;

    // Effective write enables: on a same-address collision the loser is dropped.
    always_comb begin
        ready_c = (state == READY);
        coll_c  = ready_c && we_1 && we_2 && (write_addr_1 == write_addr_2);
        wr_1_c  = ready_c && we_1 && !(coll_c && (COLL_PRIO == 1));
        wr_2_c  = ready_c && we_2 && !(coll_c && (COLL_PRIO == 0));
    end

    // Port 1 read data, with write-first bypass when selected.
    always_comb begin
        rd_1_c = mem[read_addr_1];
        if (RD_MODE == 1) begin
            if (wr_1_c && (write_addr_1 == read_addr_1)) rd_1_c = data_in_1;
            if (wr_2_c && (write_addr_2 == read_addr_1)) rd_1_c = data_in_2;
        end
    end

    // Port 2 read data, with write-first bypass when selected.
    always_comb begin
        rd_2_c = mem[read_addr_2];
        if (RD_MODE == 1) begin
            if (wr_1_c && (write_addr_1 == read_addr_2)) rd_2_c = data_in_1;
            if (wr_2_c && (write_addr_2 == read_addr_2)) rd_2_c = data_in_2;
        end
    end

    // Storage array: clear sequencer owns the write port until READY.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= CLEAR_VAL;
        end else begin
            if (wr_1_c) mem[write_addr_1] <= data_in_1;
            if (wr_2_c) mem[write_addr_2] <= data_in_2;
        end
    end

    // Clear/ready FSM with registered read, valid, busy and collision outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            busy       <= 1'b1;
            collision  <= 1'b0;
            valid_1    <= 1'b0;
            valid_2    <= 1'b0;
            data_out_1 <= '0;
            data_out_2 <= '0;
        end else begin
            collision <= coll_c;
            valid_1   <= ready_c && re_1;
            valid_2   <= ready_c && re_2;
            if (ready_c && re_1) data_out_1 <= rd_1_c;
            if (ready_c && re_2) data_out_2 <= rd_2_c;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    busy    <= 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Scoreboard bench: two RAM instances (read-first/port-1-wins and
// write-first/port-2-wins) share one stimulus stream; a behavioural model
// predicts reads, busy and collision, and a monitor checks the outputs.
module tb_dual_port_ram_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [DW-1:0] CV  = 8'hE5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          we_1, re_1, we_2, re_2;
    logic [AW-1:0] write_addr_1, read_addr_1, write_addr_2, read_addr_2;
    logic [DW-1:0] data_in_1, data_in_2;

    logic [DW-1:0] dout [4];
    logic          val  [4];
    logic          coll [2];
    logic          bsy  [2];

    dual_port_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .COLL_PRIO(0), .CLEAR_VAL(CV)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .we_1(we_1), .write_addr_1(write_addr_1), .data_in_1(data_in_1),
        .re_1(re_1), .read_addr_1(read_addr_1), .data_out_1(dout[0]), .valid_1(val[0]),
        .we_2(we_2), .write_addr_2(write_addr_2), .data_in_2(data_in_2),
        .re_2(re_2), .read_addr_2(read_addr_2), .data_out_2(dout[1]), .valid_2(val[1]),
        .busy(bsy[0]), .collision(coll[0])
    );

    dual_port_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(1), .COLL_PRIO(1), .CLEAR_VAL(CV)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .we_1(we_1), .write_addr_1(write_addr_1), .data_in_1(data_in_1),
        .re_1(re_1), .read_addr_1(read_addr_1), .data_out_1(dout[2]), .valid_1(val[2]),
        .we_2(we_2), .write_addr_2(write_addr_2), .data_in_2(data_in_2),
        .re_2(re_2), .read_addr_2(read_addr_2), .data_out_2(dout[3]), .valid_2(val[3]),
        .busy(bsy[1]), .collision(coll[1])
    );

    always #5 clk = ~clk;

    // Reference model state (index c: 0 = read-first/port 1 wins, 1 = write-first/port 2 wins)
    logic [DW-1:0] mdl [2][DEPTH];
    int            clr_cnt;
    logic          exp_busy;
    logic          exp_coll [2];
    logic          exp_val  [4];
    logic [DW-1:0] last     [4];
    logic [DW-1:0] exp_q    [4][$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
        end
    endfunction

    task automatic model_reset();
        clr_cnt  = 0;
        exp_busy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            exp_coll[c] = 1'b0;
            for (int a = 0; a < int'(DEPTH); a++) mdl[c][a] = CV;
        end
        for (int i = 0; i < 4; i++) begin
            exp_val[i] = 1'b0;
            last[i]    = '0;
            exp_q[i].delete();
        end
    endtask

    // Predict the effect of the upcoming rising edge from the current inputs.
    task automatic model_step();
        logic          re [2];
        logic [AW-1:0] ra [2];
        logic          cl, w1, w2;
        logic [DW-1:0] d;
        if (clr_cnt < int'(DEPTH)) begin
            clr_cnt++;
            exp_busy = (clr_cnt < int'(DEPTH));
            for (int c = 0; c < 2; c++) exp_coll[c] = 1'b0;
            for (int i = 0; i < 4; i++) exp_val[i] = 1'b0;
            return;
        end
        exp_busy = 1'b0;
        re[0] = re_1; ra[0] = read_addr_1;
        re[1] = re_2; ra[1] = read_addr_2;
        cl = we_1 && we_2 && (write_addr_1 == write_addr_2);
        for (int c = 0; c < 2; c++) begin
            w1 = we_1 && !(cl && c == 1);
            w2 = we_2 && !(cl && c == 0);
            for (int p = 0; p < 2; p++) begin
                d = mdl[c][ra[p]];
                if (c == 1) begin
                    if (w1 && write_addr_1 == ra[p]) d = data_in_1;
                    if (w2 && write_addr_2 == ra[p]) d = data_in_2;
                end
                exp_val[c*2+p] = re[p];
                if (re[p]) exp_q[c*2+p].push_back(d);
            end
            if (w1) mdl[c][write_addr_1] = data_in_1;
            if (w2) mdl[c][write_addr_2] = data_in_2;
            exp_coll[c] = cl;
        end
    endtask

    task automatic drive(input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic r1, input logic [AW-1:0] ra1,
                         input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                         input logic r2, input logic [AW-1:0] ra2);
        @(negedge clk);
        we_1 = w1; write_addr_1 = a1; data_in_1 = d1; re_1 = r1; read_addr_1 = ra1;
        we_2 = w2; write_addr_2 = a2; data_in_2 = d2; re_2 = r2; read_addr_2 = ra2;
        if (rst_n) model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, 0, '0, '0, 0, '0);
    endtask

    task automatic reset_seq(input int n);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) @(negedge clk);
        we_1 = 0; re_1 = 0; we_2 = 0; re_2 = 0;
        rst_n = 1'b1;
        model_step();
    endtask

    // Monitor: compare every output shortly after each rising edge.
    always @(posedge clk) begin
        logic [DW-1:0] e;
        #1;
        for (int c = 0; c < 2; c++) begin
            check("busy", c, 32'(bsy[c]), 32'(exp_busy));
            check("collision", c, 32'(coll[c]), 32'(exp_coll[c]));
        end
        for (int i = 0; i < 4; i++) begin
            check("valid", i, 32'(val[i]), 32'(exp_val[i]));
            if (val[i]) begin
                if (exp_q[i].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_read[%0d] at %0t: got %0h expected no data", i, $time, dout[i]);
                end else begin
                    e = exp_q[i].pop_front();
                    check("read_data", i, 32'(dout[i]), 32'(e));
                    last[i] = e;
                end
            end else begin
                check("hold_data", i, 32'(dout[i]), 32'(last[i]));
            end
        end
    end

    initial begin
        we_1 = 0; re_1 = 0; we_2 = 0; re_2 = 0;
        write_addr_1 = '0; read_addr_1 = '0; write_addr_2 = '0; read_addr_2 = '0;
        data_in_1 = '0; data_in_2 = '0;
        model_reset();
        #1;
        reset_seq(3);

        // Clear sequence: busy for DEPTH edges, then every word reads CLEAR_VAL
        idle(DEPTH + 1);
        for (int i = 0; i < int'(DEPTH); i += 2)
            drive(0, '0, '0, 1, AW'(i), 0, '0, '0, 1, AW'(i + 1));

        // Basic dual-port writes and cross reads
        for (int i = 0; i < 8; i++)
            drive(1, AW'(i), DW'(i + 1), 0, '0, 1, AW'(9'h100 + i), DW'(8'h81 + i), 0, '0);
        for (int i = 0; i < 8; i++)
            drive(0, '0, '0, 1, AW'(9'h100 + i), 0, '0, '0, 1, AW'(i));

        // Same-address write collision, then back-to-back collisions
        drive(1, 9'h055, 8'h11, 0, '0, 1, 9'h055, 8'h22, 0, '0);
        drive(0, '0, '0, 1, 9'h055, 0, '0, '0, 1, 9'h055);
        drive(1, 9'h056, 8'h33, 0, '0, 1, 9'h056, 8'h44, 0, '0);
        drive(1, 9'h057, 8'h55, 0, '0, 1, 9'h057, 8'h66, 0, '0);
        drive(0, '0, '0, 1, 9'h056, 0, '0, '0, 1, 9'h057);

        // Read-during-write on the same address
        drive(1, 9'h010, 8'h5A, 0, '0, 0, '0, '0, 0, '0);
        drive(1, 9'h010, 8'hC3, 0, '0, 0, '0, '0, 1, 9'h010);
        drive(0, '0, '0, 0, '0, 0, '0, '0, 1, 9'h010);

        // Single read pulse followed by hold cycles
        drive(0, '0, '0, 1, 9'h003, 0, '0, '0, 0, '0);
        idle(3);

        // Randomized traffic, biased toward a small window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] a [4];
            for (int k = 0; k < 4; k++)
                a[k] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            drive(1'($urandom), a[0], DW'($urandom), 1'($urandom), a[1],
                  1'($urandom), a[2], DW'($urandom), 1'($urandom), a[3]);
        end
        idle(2);

        // Reset in the middle of the clear sequence; writes while busy are dropped
        reset_seq(2);
        idle(6);
        reset_seq(2);
        drive(1, 9'h003, 8'hAA, 1, 9'h003, 0, '0, '0, 1, 9'h003);
        idle(DEPTH);
        drive(0, '0, '0, 1, 9'h003, 0, '0, '0, 1, 9'h003);
        idle(3);

        for (int i = 0; i < 4; i++) check("pending_reads", i, 32'(exp_q[i].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
